// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU macro sequencer: ALU op codes, macro
// opcodes, sequencer FSM states, operand source selects and flag bit
// positions. Imported by the interface, decoder and sequencer.
package alu_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int SHAMT_W_DEF    = 4;

    // Positions inside the 3-bit {zero,neg,carry} flag vector.
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_CARRY = 0;

    typedef enum logic [1:0] {
        ALU_NOR  = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_PASS = 2'b10,
        ALU_SHR  = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        MAC_NOR   = 3'b000,
        MAC_ADD   = 3'b001,
        MAC_MOV   = 3'b010,
        MAC_SHR1  = 3'b011,
        MAC_NOT   = 3'b100,
        MAC_SUB   = 3'b101,
        MAC_SHRN  = 3'b110,
        MAC_ILLEG = 3'b111
    } mac_opc_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } seq_state_e;

    // Where each ALU operand comes from during a pass.
    typedef enum logic [2:0] {
        SRC_ZERO = 3'd0,
        SRC_A    = 3'd1,
        SRC_B    = 3'd2,
        SRC_TEMP = 3'd3,
        SRC_ONE  = 3'd4
    } src_e;

endpackage

// File: rtl/alu_macro_seq_if.sv
// alu_macro_seq_if
// Bundles the command handshake, the result handshake and the ALU-facing
// bus of the macro sequencer.
//   cmd_*  : macro command in (valid/ready)
//   res_*  : result out (valid/ready) with flags and illegal-opcode error
//   alu_*  : operands/op out to the combinational ALU, result/flags back
// Modports: slave = sequencer side, master = environment (command source,
// result sink and ALU).
interface alu_macro_seq_if #(
    parameter int DATA_WIDTH = 16,
    parameter int SHAMT_W    = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_opc;
    logic [DATA_WIDTH-1:0] cmd_a;
    logic [DATA_WIDTH-1:0] cmd_b;
    logic [SHAMT_W-1:0]    cmd_shamt;

    logic [DATA_WIDTH-1:0] alu_in1;
    logic [DATA_WIDTH-1:0] alu_in2;
    logic [1:0]            alu_op;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [2:0]            alu_flag;

    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;
    logic [2:0]            res_flag;
    logic                  res_err;

    modport slave (
        input  cmd_valid, cmd_opc, cmd_a, cmd_b, cmd_shamt,
        output cmd_ready,
        output alu_in1, alu_in2, alu_op,
        input  alu_res, alu_flag,
        output res_valid, res_data, res_flag, res_err,
        input  res_ready
    );

    modport master (
        output cmd_valid, cmd_opc, cmd_a, cmd_b, cmd_shamt,
        input  cmd_ready,
        input  alu_in1, alu_in2, alu_op,
        output alu_res, alu_flag,
        input  res_valid, res_data, res_flag, res_err,
        output res_ready
    );

endinterface

// File: rtl/alu_macro_decode.sv
// alu_macro_decode
// Combinational pass table: maps (macro opcode, pass step, shift amount)
// to the ALU op, the operand source selects and whether this pass is the
// last one of the macro.
//   opc       : latched macro opcode
//   step      : current pass index (0-based)
//   shamt     : latched shift count (SHRN only)
//   alu_op    : ALU operation for this pass
//   in1_sel   : source of ALU data_in1
//   in2_sel   : source of ALU data_in2
//   last_pass : this pass produces the final result/flags
module alu_macro_decode
    import alu_pkg::*;
#(
    parameter int SHAMT_W = 4
) (
    input  mac_opc_e           opc,
    input  logic [SHAMT_W-1:0] step,
    input  logic [SHAMT_W-1:0] shamt,
    output alu_op_e            alu_op,
    output src_e               in1_sel,
    output src_e               in2_sel,
    output logic               last_pass
);

    always_comb begin
        alu_op    = ALU_NOR;
        in1_sel   = SRC_ZERO;
        in2_sel   = SRC_ZERO;
        last_pass = 1'b1;
        case (opc)
            MAC_NOR: begin
                alu_op  = ALU_NOR;
                in1_sel = SRC_A;
                in2_sel = SRC_B;
            end
            MAC_ADD: begin
                alu_op  = ALU_ADD;
                in1_sel = SRC_A;
                in2_sel = SRC_B;
            end
            MAC_MOV: begin
                alu_op  = ALU_PASS;
                in1_sel = SRC_A;
            end
            MAC_SHR1: begin
                alu_op  = ALU_SHR;
                in2_sel = SRC_B;
            end
            MAC_NOT: begin
                alu_op  = ALU_NOR;
                in1_sel = SRC_A;
                in2_sel = SRC_A;
            end
            MAC_SUB: begin
                // Two's complement of b is built in temp, then added to a.
                if (step == SHAMT_W'(0)) begin
                    alu_op    = ALU_NOR;
                    in1_sel   = SRC_B;
                    in2_sel   = SRC_B;
                    last_pass = 1'b0;
                end else if (step == SHAMT_W'(1)) begin
                    alu_op    = ALU_ADD;
                    in1_sel   = SRC_TEMP;
                    in2_sel   = SRC_ONE;
                    last_pass = 1'b0;
                end else begin
                    alu_op  = ALU_ADD;
                    in1_sel = SRC_A;
                    in2_sel = SRC_TEMP;
                end
            end
            MAC_SHRN: begin
                if (shamt == SHAMT_W'(0)) begin
                    // Zero shift still needs one pass so flags reflect b.
                    alu_op  = ALU_PASS;
                    in1_sel = SRC_B;
                end else begin
                    alu_op    = ALU_SHR;
                    in2_sel   = (step == SHAMT_W'(0)) ? SRC_B : SRC_TEMP;
                    last_pass = (step == shamt - SHAMT_W'(1));
                end
            end
            default: begin
                alu_op = ALU_NOR;
            end
        endcase
    end

endmodule

// File: rtl/alu_macro_seq.sv
// alu_macro_seq
// Multi-pass command sequencer in front of a 16-bit combinational ALU.
// Accepts a macro command, runs one ALU pass per cycle (feeding results
// back through temp) and presents the final result and final-pass flags.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : alu_macro_seq_if.slave (cmd handshake, ALU bus, res handshake)
//
// state | meaning
// IDLE  | ready for a command
// EXEC  | one ALU pass per cycle, temp <= alu_res
// DONE  | result valid, held until res_ready
module alu_macro_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SHAMT_W    = SHAMT_W_DEF
) (
    input logic              clk,
    input logic              rst,
    alu_macro_seq_if.slave   bus
);

    seq_state_e            state, next_state;
    mac_opc_e              opc_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, temp;
    logic [SHAMT_W-1:0]    shamt_q, step;
    logic [DATA_WIDTH-1:0] res_data_q;
    logic [2:0]            res_flag_q;
    logic                  res_err_q;

    alu_op_e               dec_op;
    src_e                  dec_in1, dec_in2;
    logic                  dec_last;

    logic                  cmd_ready_c, res_valid_c;
    alu_op_e               alu_op_c;
    logic [DATA_WIDTH-1:0] alu_in1_c, alu_in2_c;

    mac_opc_e              cmd_opc_c;
    assign cmd_opc_c = mac_opc_e'(bus.cmd_opc);

    alu_macro_decode #(.SHAMT_W(SHAMT_W)) u_decode (
        .opc       (opc_q),
        .step      (step),
        .shamt     (shamt_q),
        .alu_op    (dec_op),
        .in1_sel   (dec_in1),
        .in2_sel   (dec_in2),
        .last_pass (dec_last)
    );

    function automatic logic [DATA_WIDTH-1:0] src_mux(
        input src_e                  sel,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [DATA_WIDTH-1:0] t
    );
        case (sel)
            SRC_A:    return a;
            SRC_B:    return b;
            SRC_TEMP: return t;
            SRC_ONE:  return DATA_WIDTH'(1);
            default:  return '0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        cmd_ready_c = 1'b0;
        res_valid_c = 1'b0;
        alu_op_c    = ALU_NOR;
        alu_in1_c   = '0;
        alu_in2_c   = '0;
        case (state)
            ST_IDLE: begin
                // Held low while in reset so nothing looks accepted then.
                cmd_ready_c = ~rst;
                if (bus.cmd_valid) begin
                    next_state = (cmd_opc_c == MAC_ILLEG) ? ST_DONE : ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op_c  = dec_op;
                alu_in1_c = src_mux(dec_in1, a_q, b_q, temp);
                alu_in2_c = src_mux(dec_in2, a_q, b_q, temp);
                if (dec_last) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                res_valid_c = 1'b1;
                if (bus.res_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opc_q      <= MAC_NOR;
            a_q        <= '0;
            b_q        <= '0;
            shamt_q    <= '0;
            step       <= '0;
            temp       <= '0;
            res_data_q <= '0;
            res_flag_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        opc_q     <= cmd_opc_c;
                        a_q       <= bus.cmd_a;
                        b_q       <= bus.cmd_b;
                        shamt_q   <= bus.cmd_shamt;
                        step      <= '0;
                        temp      <= '0;
                        res_err_q <= 1'b0;
                        if (cmd_opc_c == MAC_ILLEG) begin
                            res_data_q            <= '0;
                            res_flag_q            <= '0;
                            res_flag_q[FLAG_ZERO] <= 1'b1;
                            res_err_q             <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    temp <= bus.alu_res;
                    step <= step + SHAMT_W'(1);
                    if (dec_last) begin
                        res_data_q <= bus.alu_res;
                        res_flag_q <= bus.alu_flag;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.res_valid = res_valid_c;
    assign bus.res_data  = res_data_q;
    assign bus.res_flag  = res_flag_q;
    assign bus.res_err   = res_err_q;
    assign bus.alu_op    = alu_op_c;
    assign bus.alu_in1   = alu_in1_c;
    assign bus.alu_in2   = alu_in2_c;

endmodule
